// File: rtl/ctrl_pkg.sv
// Shared control-bundle type, opcode/immediate encodings and sequencer state for the
// D-stage decoder and E-stage control pipeline.
package ctrl_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic       ALUSrc;
        logic       MemWrite;
        logic [1:0] ResultSrc;
        logic       Branch;
        logic [1:0] ALUOp;
        logic       Jump;
        logic       Jumplr;
        logic       MdOp;
        logic       MdDiv;
        logic       CsrOp;
        logic       Illegal;
    } ctrl_t;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpS     = 7'b0100011;
    localparam logic [6:0] OpB     = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpSys   = 7'b1110011;

    localparam logic [6:0] Funct7M = 7'b0000001;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    // ALUOp: 00 add, 01 sub/compare, 10 funct-decoded, 11 pass immediate (LUI)
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluPassB = 2'b11;

    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;
    localparam logic [1:0] ResCsr = 2'b11;

    localparam int unsigned MdCntW = $clog2(16);

    typedef enum logic [1:0] {SeqIdle, SeqBusy, SeqDone} seq_state_e;

endpackage

// File: rtl/md_seq.sv
// Multi-cycle MUL/DIV occupancy sequencer: holds the pipeline while the E-stage op is in
// flight and flags when its result is final.
module md_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic stall_i,
    input  logic md_op_i,
    input  logic md_div_i,
    output logic md_stall_o,
    output logic md_done_o
);

    localparam bit MulMulti = (MUL_LAT > 32'd1);
    localparam bit DivMulti = (DIV_LAT > 32'd1);
    localparam logic [MdCntW-1:0] MulInit = MulMulti ? MdCntW'(MUL_LAT - 32'd2) : '0;
    localparam logic [MdCntW-1:0] DivInit = DivMulti ? MdCntW'(DIV_LAT - 32'd2) : '0;

    seq_state_e        state_q;
    logic [MdCntW-1:0] cnt_q;
    logic              lat_multi;
    logic [MdCntW-1:0] cnt_init;

    assign lat_multi = md_div_i ? DivMulti : MulMulti;
    assign cnt_init  = md_div_i ? DivInit : MulInit;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= SeqIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                SeqIdle: begin
                    if (md_op_i && lat_multi) begin
                        state_q <= SeqBusy;
                        cnt_q   <= cnt_init;
                    end
                end
                SeqBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // E reloads on this edge unless held, so only park in DONE while held
                        state_q <= stall_i ? SeqDone : SeqIdle;
                    end
                end
                SeqDone: begin
                    if (!stall_i) state_q <= SeqIdle;
                end
                default: state_q <= SeqIdle;
            endcase
        end
    end

    assign md_stall_o = ((state_q == SeqIdle) && md_op_i && lat_multi) ||
                        ((state_q == SeqBusy) && (cnt_q != '0));
    assign md_done_o  = ((state_q == SeqIdle) && md_op_i && !lat_multi) ||
                        ((state_q == SeqBusy) && (cnt_q == '0)) ||
                        (state_q == SeqDone);

endmodule

// File: rtl/ctrl_decode_pipe.sv
// D-stage main decoder feeding the D->E control register, with the M-extension sequencer
// holding the pipeline while a multi-cycle MUL/DIV occupies E.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter bit          EN_M     = 1'b1,
    parameter bit          EN_ZICSR = 1'b1,
    parameter int unsigned MUL_LAT  = 1,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [2:0]  ImmSrcD,
    output ctrl_t       CtrlE,
    output logic        MdStallE,
    output logic        MdDoneE
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e_q;
    logic       illegal_d;
    logic       md_stall;
    logic       unused_instr_bits;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];
    assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        ImmSrcD   = ImmI;
        case (opcode)
            OpR: begin
                ctrl_d.RegWrite = 1'b1;
                ctrl_d.ALUOp    = AluFunct;
                if (funct7 == Funct7M) begin
                    if (EN_M) begin
                        ctrl_d.MdOp  = 1'b1;
                        ctrl_d.MdDiv = funct3[2];
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            OpIAlu: begin
                ctrl_d.RegWrite = 1'b1;
                ctrl_d.ALUSrc   = 1'b1;
                ctrl_d.ALUOp    = AluFunct;
            end
            OpLoad: begin
                ctrl_d.RegWrite  = 1'b1;
                ctrl_d.ALUSrc    = 1'b1;
                ctrl_d.ResultSrc = ResMem;
            end
            OpS: begin
                ImmSrcD         = ImmS;
                ctrl_d.ALUSrc   = 1'b1;
                ctrl_d.MemWrite = 1'b1;
            end
            OpB: begin
                ImmSrcD       = ImmB;
                ctrl_d.Branch = 1'b1;
                ctrl_d.ALUOp  = AluSub;
            end
            OpJal: begin
                ImmSrcD          = ImmJ;
                ctrl_d.RegWrite  = 1'b1;
                ctrl_d.ResultSrc = ResPc4;
                ctrl_d.Jump      = 1'b1;
            end
            OpJalr: begin
                ctrl_d.RegWrite  = 1'b1;
                ctrl_d.ALUSrc    = 1'b1;
                ctrl_d.ResultSrc = ResPc4;
                ctrl_d.Jumplr    = 1'b1;
            end
            OpLui: begin
                ImmSrcD         = ImmU;
                ctrl_d.RegWrite = 1'b1;
                ctrl_d.ALUSrc   = 1'b1;
                ctrl_d.ALUOp    = AluPassB;
            end
            OpAuipc: begin
                ImmSrcD         = ImmU;
                ctrl_d.RegWrite = 1'b1;
                ctrl_d.ALUSrc   = 1'b1;
                ctrl_d.ALUOp    = AluAdd;
            end
            OpSys: begin
                // ecall/ebreak decode to an all-zero bundle
                if (funct3 != 3'b000) begin
                    if (EN_ZICSR) begin
                        ctrl_d.CsrOp     = 1'b1;
                        ctrl_d.RegWrite  = 1'b1;
                        ctrl_d.ResultSrc = ResCsr;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            ctrl_d         = '0;
            ctrl_d.Illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ctrl_e_q <= '0;
        end else if (!(StallE || md_stall)) begin
            ctrl_e_q <= ctrl_d;
        end
    end

    assign CtrlE    = ctrl_e_q;
    assign MdStallE = md_stall;

    md_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_seq (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (FlushE),
        .stall_i    (StallE),
        .md_op_i    (ctrl_e_q.MdOp),
        .md_div_i   (ctrl_e_q.MdDiv),
        .md_stall_o (md_stall),
        .md_done_o  (MdDoneE)
    );

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode table, E-register stall/flush and the
// MUL/DIV sequencer timing, with a second instance built without M and Zicsr.
module tb_ctrl_decode_pipe;
    import ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic        StallE;
    logic        FlushE;
    logic [2:0]  imm_src;
    ctrl_t       ctrl_e;
    logic        md_stall;
    logic        md_done;
    logic [2:0]  imm_src_nm;
    ctrl_t       ctrl_e_nm;
    logic        md_stall_nm;
    logic        md_done_nm;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] INOP  = 32'h0000_0013;
    localparam logic [31:0] IDIV  = 32'h0200_4033;
    localparam logic [31:0] IMUL  = 32'h0200_0033;
    localparam logic [31:0] ISW   = 32'h0000_2023;
    localparam logic [31:0] ICSR  = 32'h0000_1073;
    localparam logic [31:0] IFNC  = 32'h0000_000f;

    ctrl_decode_pipe #(
        .EN_M(1'b1), .EN_ZICSR(1'b1), .MUL_LAT(1), .DIV_LAT(8)
    ) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
        .ImmSrcD(imm_src), .CtrlE(ctrl_e), .MdStallE(md_stall), .MdDoneE(md_done)
    );

    ctrl_decode_pipe #(
        .EN_M(1'b0), .EN_ZICSR(1'b0), .MUL_LAT(1), .DIV_LAT(8)
    ) dut_nm (
        .clk(clk), .reset(reset), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
        .ImmSrcD(imm_src_nm), .CtrlE(ctrl_e_nm), .MdStallE(md_stall_nm),
        .MdDoneE(md_done_nm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic rw, input logic as, input logic mw,
                                       input logic [1:0] rs, input logic br,
                                       input logic [1:0] aop, input logic j, input logic jr,
                                       input logic md, input logic mdd, input logic csr,
                                       input logic ill);
        return {rw, as, mw, rs, br, aop, j, jr, md, mdd, csr, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; InstrD = INOP; StallE = 1'b0; FlushE = 1'b0;
        step(); step();
        checks++;
        if (ctrl_e !== 15'd0 || md_stall !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: CtrlE=%h MdStallE=%b MdDoneE=%b, want 0/0/0",
                     ctrl_e, md_stall, md_done);
        end
        checks++;
        if (ctrl_e_nm !== 15'd0 || md_stall_nm !== 1'b0 || md_done_nm !== 1'b0) begin
            errors++;
            $display("FAIL reset_nm: CtrlE=%h MdStallE=%b MdDoneE=%b, want 0/0/0",
                     ctrl_e_nm, md_stall_nm, md_done_nm);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_decode_sweep();
        logic [31:0] ins [11];
        logic [14:0] exp_c [11];
        logic [2:0]  exp_i [11];
        ins[0]  = 32'h0000_0033; exp_c[0]  = mk(1,0,0,2'b00,0,2'b10,0,0,0,0,0,0); exp_i[0]  = 3'b000;
        ins[1]  = 32'h0000_0013; exp_c[1]  = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0); exp_i[1]  = 3'b000;
        ins[2]  = 32'h0000_2003; exp_c[2]  = mk(1,1,0,2'b01,0,2'b00,0,0,0,0,0,0); exp_i[2]  = 3'b000;
        ins[3]  = ISW;           exp_c[3]  = mk(0,1,1,2'b00,0,2'b00,0,0,0,0,0,0); exp_i[3]  = 3'b001;
        ins[4]  = 32'h0000_0063; exp_c[4]  = mk(0,0,0,2'b00,1,2'b01,0,0,0,0,0,0); exp_i[4]  = 3'b010;
        ins[5]  = 32'h0000_006f; exp_c[5]  = mk(1,0,0,2'b10,0,2'b00,1,0,0,0,0,0); exp_i[5]  = 3'b011;
        ins[6]  = 32'h0000_0067; exp_c[6]  = mk(1,1,0,2'b10,0,2'b00,0,1,0,0,0,0); exp_i[6]  = 3'b000;
        ins[7]  = 32'h0000_0037; exp_c[7]  = mk(1,1,0,2'b00,0,2'b11,0,0,0,0,0,0); exp_i[7]  = 3'b100;
        ins[8]  = 32'h0000_0017; exp_c[8]  = mk(1,1,0,2'b00,0,2'b00,0,0,0,0,0,0); exp_i[8]  = 3'b100;
        ins[9]  = 32'h0000_0073; exp_c[9]  = mk(0,0,0,2'b00,0,2'b00,0,0,0,0,0,0); exp_i[9]  = 3'b000;
        ins[10] = ICSR;          exp_c[10] = mk(1,0,0,2'b11,0,2'b00,0,0,0,0,1,0); exp_i[10] = 3'b000;
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                checks++;
                if (ctrl_e !== exp_c[i-1]) begin
                    errors++;
                    $display("FAIL sweep_ctrl[%0d]: CtrlE=%h, want %h", i - 1, ctrl_e, exp_c[i-1]);
                end
            end
            if (i < 11) begin
                InstrD = ins[i];
                #1;
                checks++;
                if (imm_src !== exp_i[i]) begin
                    errors++;
                    $display("FAIL sweep_imm[%0d]: ImmSrcD=%b, want %b", i, imm_src, exp_i[i]);
                end
                step();
            end
        end
        InstrD = INOP;
        step();
    endtask

    task automatic test_illegal();
        logic [14:0] ill;
        ill = mk(0,0,0,2'b00,0,2'b00,0,0,0,0,0,1);
        InstrD = IFNC;
        step();
        checks++;
        if (ctrl_e !== ill) begin
            errors++;
            $display("FAIL illegal_opcode: CtrlE=%h, want %h", ctrl_e, ill);
        end
        InstrD = ICSR;
        step();
        checks++;
        if (ctrl_e_nm !== ill) begin
            errors++;
            $display("FAIL illegal_csr_nozicsr: CtrlE=%h, want %h", ctrl_e_nm, ill);
        end
        InstrD = IDIV;
        step();
        checks++;
        if (ctrl_e_nm !== ill || md_stall_nm !== 1'b0) begin
            errors++;
            $display("FAIL illegal_div_nom: CtrlE=%h MdStallE=%b, want %h/0",
                     ctrl_e_nm, md_stall_nm, ill);
        end
        InstrD = INOP;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_stall_flush_e();
        logic [14:0] e_addi, e_sw;
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        e_sw   = mk(0,1,1,2'b00,0,2'b00,0,0,0,0,0,0);
        InstrD = INOP;
        step();
        StallE = 1'b1; InstrD = ISW;
        step();
        checks++;
        if (ctrl_e !== e_addi) begin
            errors++;
            $display("FAIL stall_hold: CtrlE=%h, want %h", ctrl_e, e_addi);
        end
        FlushE = 1'b1;
        step();
        checks++;
        if (ctrl_e !== 15'd0) begin
            errors++;
            $display("FAIL flush_over_stall: CtrlE=%h, want 0", ctrl_e);
        end
        FlushE = 1'b0; StallE = 1'b0;
        step();
        checks++;
        if (ctrl_e !== e_sw) begin
            errors++;
            $display("FAIL reload_after_stall: CtrlE=%h, want %h", ctrl_e, e_sw);
        end
        InstrD = INOP;
        step();
    endtask

    task automatic test_mul_single();
        logic [14:0] e_mul, e_addi;
        e_mul  = mk(1,0,0,2'b00,0,2'b10,0,0,1,0,0,0);
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        InstrD = IMUL;
        step();
        InstrD = INOP;
        checks++;
        if (ctrl_e !== e_mul || md_stall !== 1'b0 || md_done !== 1'b1) begin
            errors++;
            $display("FAIL mul_single: CtrlE=%h MdStallE=%b MdDoneE=%b, want %h/0/1",
                     ctrl_e, md_stall, md_done, e_mul);
        end
        step();
        checks++;
        if (ctrl_e !== e_addi || md_stall !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL mul_next: CtrlE=%h MdStallE=%b MdDoneE=%b, want %h/0/0",
                     ctrl_e, md_stall, md_done, e_addi);
        end
    endtask

    task automatic test_div_latency();
        logic [14:0] e_div, e_addi;
        e_div  = mk(1,0,0,2'b00,0,2'b10,0,0,1,1,0,0);
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        InstrD = IDIV;
        step();
        InstrD = INOP;
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (md_stall !== 1'b1 || md_done !== 1'b0 || ctrl_e !== e_div) begin
                errors++;
                $display("FAIL div_busy[%0d]: MdStallE=%b MdDoneE=%b CtrlE=%h, want 1/0/%h",
                         k, md_stall, md_done, ctrl_e, e_div);
            end
            step();
        end
        checks++;
        if (md_stall !== 1'b0 || md_done !== 1'b1 || ctrl_e !== e_div) begin
            errors++;
            $display("FAIL div_done: MdStallE=%b MdDoneE=%b CtrlE=%h, want 0/1/%h",
                     md_stall, md_done, ctrl_e, e_div);
        end
        step();
        checks++;
        if (md_stall !== 1'b0 || md_done !== 1'b0 || ctrl_e !== e_addi) begin
            errors++;
            $display("FAIL div_next: MdStallE=%b MdDoneE=%b CtrlE=%h, want 0/0/%h",
                     md_stall, md_done, ctrl_e, e_addi);
        end
    endtask

    task automatic test_div_flush();
        logic [14:0] e_addi;
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        InstrD = IDIV;
        step();
        InstrD = INOP;
        step(); step(); step();
        checks++;
        if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL div_flush_pre: MdStallE=%b, want 1", md_stall);
        end
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        checks++;
        if (ctrl_e !== 15'd0 || md_stall !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL div_flush: CtrlE=%h MdStallE=%b MdDoneE=%b, want 0/0/0",
                     ctrl_e, md_stall, md_done);
        end
        step();
        checks++;
        if (ctrl_e !== e_addi || md_stall !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL div_flush_idle: CtrlE=%h MdStallE=%b MdDoneE=%b, want %h/0/0",
                     ctrl_e, md_stall, md_done, e_addi);
        end
    endtask

    task automatic test_div_stall_done();
        logic [14:0] e_div, e_addi;
        e_div  = mk(1,0,0,2'b00,0,2'b10,0,0,1,1,0,0);
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        InstrD = IDIV;
        step();
        InstrD = INOP;
        for (int k = 0; k < 6; k++) step();
        StallE = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            step();
            checks++;
            if (md_done !== 1'b1 || md_stall !== 1'b0 || ctrl_e !== e_div) begin
                errors++;
                $display("FAIL div_hold_done[%0d]: MdDoneE=%b MdStallE=%b CtrlE=%h, want 1/0/%h",
                         k, md_done, md_stall, ctrl_e, e_div);
            end
        end
        StallE = 1'b0;
        step();
        checks++;
        if (ctrl_e !== e_addi || md_done !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL div_release: CtrlE=%h MdDoneE=%b MdStallE=%b, want %h/0/0",
                     ctrl_e, md_done, md_stall, e_addi);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [14:0] e_addi;
        e_addi = mk(1,1,0,2'b00,0,2'b10,0,0,0,0,0,0);
        InstrD = IDIV;
        step();
        InstrD = INOP;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (ctrl_e !== 15'd0 || md_stall !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: CtrlE=%h MdStallE=%b MdDoneE=%b, want 0/0/0",
                     ctrl_e, md_stall, md_done);
        end
        step();
        checks++;
        if (ctrl_e !== e_addi || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_then_idle: CtrlE=%h MdStallE=%b, want %h/0",
                     ctrl_e, md_stall, e_addi);
        end
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_illegal();
        test_stall_flush_e();
        test_mul_single();
        test_div_latency();
        test_div_flush();
        test_div_stall_done();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
